// File: rtl/rgmii_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the RGMII transmit adapter: link speeds, FSM states and
// the TX_CTL falling-half encoder.
package rgmii_pkg;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_NIB_HI,
        ST_IFG
    } state_t;

    // Falling-half TX_CTL value; er has no meaning outside a frame, so idle stays 0.
    function automatic logic enc_ctl(input logic en, input logic er, input logic er_encode);
        if (!en) return 1'b0;
        return er_encode ? (en ^ er) : er;
    endfunction

endpackage

// File: rtl/rgmii_oddr.sv
`timescale 1ns/1ps
// One-bit DDR output cell: behavioural stand-in for the vendor ODDR primitive
// (both halves captured on the rising edge, rise half driven while clk is high).
module rgmii_oddr (
    input  logic clk,
    input  logic rst_n,
    input  logic d_rise,
    input  logic d_fall,
    output logic q
);

    logic rise_q;
    logic fall_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the async clear forces the pin low without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= d_rise;
            fall_q <= d_fall;
        end
    end

    assign q = clk ? rise_q : fall_q;

endmodule

// File: rtl/rgmii_tx_adapt.sv
`timescale 1ns/1ps
// Tri-speed GMII->RGMII transmit adapter: byte handshake from the MAC, nibble pipe
// into per-bit DDR cells, inter-frame gap enforcement and TX_ER onto TX_CTL.
module rgmii_tx_adapt
    import rgmii_pkg::*;
#(
    parameter int IFG_BYTES = 12,
    parameter bit ER_ENCODE = 1'b1
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic [1:0] speed_sel,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    input  logic [7:0] gmii_txd,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       rgmii_txc,
    output logic       rgmii_tx_ctl,
    output logic [3:0] rgmii_txd
);

    localparam int IFG_W = (IFG_BYTES > 0) ? $clog2(2 * IFG_BYTES + 1) : 1;
    localparam logic [IFG_W-1:0] IFG_LOAD_GIG = IFG_W'(IFG_BYTES);
    // The end-of-frame cycle already spent one nibble time of the gap.
    localparam logic [IFG_W-1:0] IFG_LOAD_NIB = IFG_W'(2 * IFG_BYTES - 1);

    state_t           state, state_d;
    logic [1:0]       speed_q, speed_d;
    logic             ready_q, ready_d;
    logic [3:0]       hi_q, hi_d;
    logic             er_q, er_d;
    logic [IFG_W-1:0] ifg_cnt, ifg_d;
    logic [3:0]       rise_q, rise_d, fall_q, fall_d;
    logic             crise_q, crise_d, cfall_q, cfall_d;
    logic             is_gig;
    logic             accept;

    assign is_gig = !((speed_q == SPD_10) || (speed_q == SPD_100));
    assign accept = gmii_tx_en & ready_q;

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a value unassigned and a latch cannot be inferred.
    always_comb begin
        state_d = state;
        speed_d = speed_q;
        hi_d    = hi_q;
        er_d    = er_q;
        ifg_d   = ifg_cnt;
        rise_d  = 4'h0;
        fall_d  = 4'h0;
        crise_d = 1'b0;
        cfall_d = 1'b0;

        unique case (state)
            ST_IDLE, ST_SEND: begin
                if (accept) begin
                    crise_d = 1'b1;
                    cfall_d = enc_ctl(1'b1, gmii_tx_er, ER_ENCODE);
                    rise_d  = gmii_txd[3:0];
                    if (is_gig) begin
                        fall_d  = gmii_txd[7:4];
                        state_d = ST_SEND;
                    end else begin
                        fall_d  = gmii_txd[3:0];
                        hi_d    = gmii_txd[7:4];
                        er_d    = gmii_tx_er;
                        state_d = ST_NIB_HI;
                    end
                end else if (state == ST_IDLE) begin
                    speed_d = speed_sel;
                end else if (IFG_BYTES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_d   = is_gig ? IFG_LOAD_GIG : IFG_LOAD_NIB;
                    state_d = ST_IFG;
                end
            end
            ST_NIB_HI: begin
                rise_d  = hi_q;
                fall_d  = hi_q;
                crise_d = 1'b1;
                cfall_d = enc_ctl(1'b1, er_q, ER_ENCODE);
                state_d = ST_SEND;
            end
            ST_IFG: begin
                if (ifg_cnt <= IFG_W'(1)) state_d = ST_IDLE;
                else                      ifg_d   = ifg_cnt - IFG_W'(1);
            end
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_SEND);
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            speed_q <= SPD_1000;
            ready_q <= 1'b0;
            hi_q    <= 4'h0;
            er_q    <= 1'b0;
            ifg_cnt <= '0;
            rise_q  <= 4'h0;
            fall_q  <= 4'h0;
            crise_q <= 1'b0;
            cfall_q <= 1'b0;
        end else begin
            state   <= state_d;
            speed_q <= speed_d;
            ready_q <= ready_d;
            hi_q    <= hi_d;
            er_q    <= er_d;
            ifg_cnt <= ifg_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            crise_q <= crise_d;
            cfall_q <= cfall_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = (state != ST_IDLE);

    rgmii_oddr u_oddr_txc (
        .clk    (gmii_tx_clk),
        .rst_n  (rst_n),
        .d_rise (1'b1),
        .d_fall (1'b0),
        .q      (rgmii_txc)
    );

    rgmii_oddr u_oddr_ctl (
        .clk    (gmii_tx_clk),
        .rst_n  (rst_n),
        .d_rise (crise_q),
        .d_fall (cfall_q),
        .q      (rgmii_tx_ctl)
    );

    for (genvar i = 0; i < 4; i++) begin : g_txd
        rgmii_oddr u_oddr_txd (
            .clk    (gmii_tx_clk),
            .rst_n  (rst_n),
            .d_rise (rise_q[i]),
            .d_fall (fall_q[i]),
            .q      (rgmii_txd[i])
        );
    end

endmodule
